// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the RV32I multi-cycle control unit.
package rv_ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MUL  = 7'b0000001;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_MUL  = 4'b0011;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SRA  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;
  localparam logic [3:0] ALU_XOR  = 4'b1100;
  localparam logic [3:0] ALU_SLL  = 4'b1101;
  localparam logic [3:0] ALU_SRL  = 4'b1110;

  localparam logic [1:0] PC_PLUS4  = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JALR   = 2'b10;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC  = 2'b10;
  localparam logic [1:0] WB_IMM = 2'b11;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd5
  } state_t;

endpackage

// File: rtl/rv_multicycle_ctrl_alu_decode.sv
// Combinational opcode/funct decode: ALU operation code and legality.
module rv_alu_decode
  import rv_ctrl_pkg::*;
#(
  parameter int ENABLE_MUL = 0
) (
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic [6:0] funct7_i,
  output logic [3:0] alu_code_o,
  output logic       legal_o,
  output logic       is_mul_o
);

  // Shared R/I arithmetic table; only register ops may turn ADD into SUB.
  function automatic logic [3:0] arith_code(input logic [2:0] f3, input logic alt,
                                            input logic is_reg);
    case (f3)
      3'b000:  arith_code = (alt && is_reg) ? ALU_SUB : ALU_ADD;
      3'b001:  arith_code = ALU_SLL;
      3'b010:  arith_code = ALU_SLT;
      3'b011:  arith_code = ALU_SLTU;
      3'b100:  arith_code = ALU_XOR;
      3'b101:  arith_code = alt ? ALU_SRA : ALU_SRL;
      3'b110:  arith_code = ALU_OR;
      default: arith_code = ALU_AND;
    endcase
  endfunction

  // Decode operation and legality from the instruction fields.
  always_comb begin
    alu_code_o = ALU_ADD;
    legal_o    = 1'b0;
    is_mul_o   = 1'b0;
    case (opcode_i)
      OP_R: begin
        if (funct7_i == F7_MUL) begin
          is_mul_o   = (ENABLE_MUL != 0) && (funct3_i == 3'b000);
          legal_o    = is_mul_o;
          alu_code_o = ALU_MUL;
        end else begin
          legal_o    = (funct7_i == F7_BASE) || (funct7_i == F7_ALT);
          alu_code_o = arith_code(funct3_i, funct7_i[5], 1'b1);
        end
      end
      OP_I: begin
        legal_o    = 1'b1;
        alu_code_o = arith_code(funct3_i, funct7_i[5], 1'b0);
      end
      OP_BRANCH: begin
        legal_o = (funct3_i[2:1] != 2'b01);
        case (funct3_i[2:1])
          2'b10:   alu_code_o = ALU_SLT;
          2'b11:   alu_code_o = ALU_SLTU;
          default: alu_code_o = ALU_SUB;
        endcase
      end
      OP_LOAD, OP_STORE, OP_JAL, OP_JALR, OP_LUI: legal_o = 1'b1;
      default: legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/rv_multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: fetch, decode, execute, memory, writeback.
module rv_multicycle_ctrl
  import rv_ctrl_pkg::*;
#(
  parameter int ALUCTL_W   = 4,
  parameter int ENABLE_MUL = 0,
  parameter int MUL_LAT    = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         instr,
  input  logic                imem_ready,
  input  logic                dmem_ready,
  input  logic                alu_zero,
  input  logic                alu_lt,
  input  logic                alu_ltu,
  output logic                imem_req,
  output logic                ir_write,
  output logic                pc_write,
  output logic                oldpc_write,
  output logic [1:0]          pc_src,
  output logic                alu_src_a,
  output logic                alu_src_b,
  output logic [ALUCTL_W-1:0] alu_ctl,
  output logic                dmem_req,
  output logic                dmem_we,
  output logic                reg_write,
  output logic [1:0]          wb_sel,
  output logic                illegal,
  output logic                busy_mul
);

  localparam logic [3:0] MUL_LAST = 4'(MUL_LAT - 1);

  state_t     state_q, state_d;
  logic [3:0] mul_cnt_q, mul_cnt_d;
  logic       illegal_q, illegal_d;
  logic [3:0] dec_code, alu_code_c;
  logic       dec_legal, dec_mul, br_taken;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       unused_instr_bits;

  assign opcode            = instr[6:0];
  assign funct3            = instr[14:12];
  assign unused_instr_bits = ^{instr[24:15], instr[11:7]};

  rv_alu_decode #(.ENABLE_MUL(ENABLE_MUL)) u_dec (
    .opcode_i   (opcode),
    .funct3_i   (funct3),
    .funct7_i   (instr[31:25]),
    .alu_code_o (dec_code),
    .legal_o    (dec_legal),
    .is_mul_o   (dec_mul)
  );

  // Branch condition from the ALU flags; funct3[0] inverts the sense.
  always_comb begin
    case (funct3[2:1])
      2'b00:   br_taken = alu_zero ^ funct3[0];
      2'b10:   br_taken = alu_lt   ^ funct3[0];
      2'b11:   br_taken = alu_ltu  ^ funct3[0];
      default: br_taken = 1'b0;
    endcase
  end

  // Next state and datapath controls; everything is forced low during reset.
  always_comb begin
    state_d     = state_q;
    mul_cnt_d   = mul_cnt_q;
    illegal_d   = illegal_q;
    imem_req    = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    oldpc_write = 1'b0;
    pc_src      = PC_PLUS4;
    alu_src_a   = 1'b0;
    alu_src_b   = 1'b0;
    alu_code_c  = ALU_AND;
    dmem_req    = 1'b0;
    dmem_we     = 1'b0;
    reg_write   = 1'b0;
    wb_sel      = WB_ALU;
    illegal     = illegal_q;
    busy_mul    = 1'b0;
    case (state_q)
      FETCH: begin
        imem_req    = 1'b1;
        oldpc_write = 1'b1;
        if (imem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          pc_src   = PC_PLUS4;
          state_d  = DECODE;
        end
      end
      DECODE: begin
        if (!dec_legal) begin
          illegal_d = 1'b1;
          state_d   = TRAP;
        end else begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        alu_code_c = dec_code;
        case (opcode)
          OP_R: begin
            if (dec_mul) begin
              busy_mul = 1'b1;
              if (mul_cnt_q == MUL_LAST) begin
                mul_cnt_d = 4'd0;
                state_d   = WB;
              end else begin
                mul_cnt_d = mul_cnt_q + 4'd1;
              end
            end else begin
              state_d = WB;
            end
          end
          OP_I, OP_LUI: begin
            alu_src_b = 1'b1;
            state_d   = WB;
          end
          OP_LOAD, OP_STORE: begin
            alu_src_b = 1'b1;
            state_d   = MEM;
          end
          OP_BRANCH: begin
            if (br_taken) begin
              pc_write = 1'b1;
              pc_src   = PC_BRANCH;
            end
            state_d = FETCH;
          end
          OP_JAL: begin
            alu_src_a = 1'b1;
            alu_src_b = 1'b1;
            pc_write  = 1'b1;
            pc_src    = PC_BRANCH;
            state_d   = WB;
          end
          OP_JALR: begin
            alu_src_b = 1'b1;
            pc_write  = 1'b1;
            pc_src    = PC_JALR;
            state_d   = WB;
          end
          default: state_d = TRAP;
        endcase
      end
      MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (opcode == OP_STORE);
        if (dmem_ready) state_d = (opcode == OP_STORE) ? FETCH : WB;
      end
      WB: begin
        reg_write = 1'b1;
        case (opcode)
          OP_LOAD:         wb_sel = WB_MEM;
          OP_JAL, OP_JALR: wb_sel = WB_PC;
          OP_LUI:          wb_sel = WB_IMM;
          default:         wb_sel = WB_ALU;
        endcase
        state_d = FETCH;
      end
      TRAP: illegal = 1'b1;
      default: state_d = FETCH;
    endcase
    if (rst) begin
      imem_req    = 1'b0;
      ir_write    = 1'b0;
      pc_write    = 1'b0;
      oldpc_write = 1'b0;
      pc_src      = 2'b00;
      alu_src_a   = 1'b0;
      alu_src_b   = 1'b0;
      alu_code_c  = 4'd0;
      dmem_req    = 1'b0;
      dmem_we     = 1'b0;
      reg_write   = 1'b0;
      wb_sel      = 2'b00;
      illegal     = 1'b0;
      busy_mul    = 1'b0;
    end
  end

  assign alu_ctl = ALUCTL_W'(alu_code_c);

  // State, multiply counter and sticky illegal flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FETCH;
      mul_cnt_q <= 4'd0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mul_cnt_q <= mul_cnt_d;
      illegal_q <= illegal_d;
    end
  end

endmodule
